// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter giving four requesters one setup/load/hold cycle each on a shared register.
// Define REG_LOAD_ARBITER_READBACK_EN to add a VERIFY readback step that drives a sticky Error flag.
module reg_load_arbiter #(
  parameter int N = 4
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [3:0]     Request,
  input  logic [4*N-1:0] RequestData,
  output logic [3:0]     Grant,
  output logic [3:0]     Done,
  output logic           RegLoad,
  output logic           RegEnable,
  output logic [N-1:0]   RegInputData,
  input  logic [N-1:0]   RegOutputData,
  output logic           Busy,
  output logic           Error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_VERIFY = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]   state_reg;
  logic [2:0]   state_next;
  logic [1:0]   ptr_reg;
  logic [1:0]   winner_reg;
  logic [1:0]   pick;
  logic         found;
  logic [N-1:0] data_reg;
  logic [N-1:0] req_data [4];
  logic [3:0]   winner_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign req_data[gi]      = RequestData[gi*N +: N];
      assign winner_onehot[gi] = (winner_reg == 2'(gi));
    end
  endgenerate

  // Search starts at ptr and wraps modulo 4; 2-bit arithmetic supplies the wrap.
  always_comb begin
    pick  = ptr_reg;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && Request[ptr_reg + 2'(i)]) begin
        found = 1'b1;
        pick  = ptr_reg + 2'(i);
      end
    end
  end

  always_comb begin
    state_next = S_IDLE;
    case (state_reg)
      S_IDLE:   state_next = (|Request) ? S_SETUP : S_IDLE;
      S_SETUP:  state_next = S_LOAD;
      S_LOAD:   state_next = S_HOLD;
`ifdef REG_LOAD_ARBITER_READBACK_EN
      S_HOLD:   state_next = S_VERIFY;
`else
      S_HOLD:   state_next = S_DONE;
`endif
      S_VERIFY: state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_reg  <= S_IDLE;
      ptr_reg    <= 2'd0;
      winner_reg <= 2'd0;
      data_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_IDLE && found) begin
        winner_reg <= pick;
        data_reg   <= req_data[pick];
      end
      if (state_reg == S_DONE) begin
        ptr_reg <= winner_reg + 2'd1;
      end
    end
  end

  // Outputs are registered decodes of the state, so they trail the state register by one cycle.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      Grant        <= 4'b0;
      Done         <= 4'b0;
      RegLoad      <= 1'b0;
      RegEnable    <= 1'b0;
      RegInputData <= '0;
      Busy         <= 1'b0;
    end else begin
      Busy    <= (state_reg != S_IDLE);
      RegLoad <= (state_reg == S_LOAD);
      Done    <= (state_reg == S_DONE) ? winner_onehot : 4'b0;
      if (state_reg == S_SETUP || state_reg == S_LOAD ||
          state_reg == S_HOLD  || state_reg == S_VERIFY) begin
        Grant     <= winner_onehot;
        RegEnable <= 1'b1;
      end else begin
        Grant     <= 4'b0;
        RegEnable <= 1'b0;
      end
      if (state_reg == S_SETUP) begin
        RegInputData <= data_reg;
      end
    end
  end

`ifdef REG_LOAD_ARBITER_READBACK_EN
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      Error <= 1'b0;
    end else if (state_reg == S_VERIFY && RegOutputData != data_reg) begin
      Error <= 1'b1;
    end
  end
`else
  logic unused_readback;
  assign unused_readback = ^RegOutputData;
  assign Error           = 1'b0;
`endif

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter: single load, contention, pointer wrap, abort by Clear and readback error.
module tb_reg_load_arbiter;

`ifdef REG_LOAD_ARBITER_READBACK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [3:0]  Request = 4'b0;
  logic [15:0] RequestData = 16'h0;
  logic [3:0]  Grant;
  logic [3:0]  Done;
  logic        RegLoad;
  logic        RegEnable;
  logic [3:0]  RegInputData;
  logic [3:0]  RegOutputData;
  logic        Busy;
  logic        Error;

  logic [3:0]  reg_q;
  logic        corrupt = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  reg_load_arbiter #(.N(4)) dut (
    .Clock(Clock),
    .Clear(Clear),
    .Request(Request),
    .RequestData(RequestData),
    .Grant(Grant),
    .Done(Done),
    .RegLoad(RegLoad),
    .RegEnable(RegEnable),
    .RegInputData(RegInputData),
    .RegOutputData(RegOutputData),
    .Busy(Busy),
    .Error(Error)
  );

  always #5 Clock = ~Clock;

  // Shared register model; with corrupt set it returns 0x5 for a load of 0x6.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) reg_q <= 4'h0;
    else if (RegLoad && RegEnable) reg_q <= (corrupt && RegInputData == 4'h6) ? 4'h5 : RegInputData;
  end
  assign RegOutputData = reg_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    Clear = 1'b0;
    #1;
    check({tag, "/rst_grant"}, 32'(Grant), 0);
    check({tag, "/rst_done"}, 32'(Done), 0);
    check({tag, "/rst_load"}, 32'(RegLoad), 0);
    check({tag, "/rst_enable"}, 32'(RegEnable), 0);
    check({tag, "/rst_data"}, 32'(RegInputData), 0);
    check({tag, "/rst_busy"}, 32'(Busy), 0);
    check({tag, "/rst_error"}, 32'(Error), 0);
    tick();
    tick();
    Clear = 1'b1;
  endtask

  // Request must be presented before the call; the next edge is the sampling edge k.
  task automatic run_txn(input string tag, input logic [3:0] g, input logic [3:0] d, input bit drop);
    tick();
    check({tag, "/k_busy"}, 32'(Busy), 0);
    check({tag, "/k_grant"}, 32'(Grant), 0);
    if (drop) begin
      Request     = 4'b0;
      RequestData = 16'hFFFF;
    end
    tick();
    check({tag, "/setup_grant"}, 32'(Grant), 32'(g));
    check({tag, "/setup_enable"}, 32'(RegEnable), 1);
    check({tag, "/setup_load"}, 32'(RegLoad), 0);
    check({tag, "/setup_data"}, 32'(RegInputData), 32'(d));
    check({tag, "/setup_busy"}, 32'(Busy), 1);
    tick();
    check({tag, "/load_load"}, 32'(RegLoad), 1);
    check({tag, "/load_data"}, 32'(RegInputData), 32'(d));
    check({tag, "/load_grant"}, 32'(Grant), 32'(g));
    tick();
    check({tag, "/hold_load"}, 32'(RegLoad), 0);
    check({tag, "/hold_enable"}, 32'(RegEnable), 1);
    check({tag, "/hold_data"}, 32'(RegInputData), 32'(d));
`ifdef REG_LOAD_ARBITER_READBACK_EN
    tick();
    check({tag, "/verify_done"}, 32'(Done), 0);
    check({tag, "/verify_load"}, 32'(RegLoad), 0);
`endif
    tick();
    check({tag, "/done_done"}, 32'(Done), 32'(g));
    check({tag, "/done_grant"}, 32'(Grant), 0);
    check({tag, "/done_enable"}, 32'(RegEnable), 0);
    check({tag, "/done_data"}, 32'(RegInputData), 32'(d));
  endtask

  initial begin
    #2;
    do_reset("init");

    // Single request; request dropped and data changed after latch.
    Request     = 4'b0001;
    RequestData = 16'h000A;
    run_txn("single", 4'b0001, 4'hA, 1'b1);
    tick();
    check("single/after_done", 32'(Done), 0);
    check("single/after_busy", 32'(Busy), 0);
    check("single/after_data_held", 32'(RegInputData), 32'hA);
    check("single/after_load", 32'(RegLoad), 0);

    // Contention from ptr=0 with all four held.
    do_reset("pre_contention");
    Request     = 4'b1111;
    RequestData = 16'h4321;
    run_txn("rr0", 4'b0001, 4'h1, 1'b0);
    run_txn("rr1", 4'b0010, 4'h2, 1'b0);
    run_txn("rr2", 4'b0100, 4'h3, 1'b0);
    run_txn("rr3", 4'b1000, 4'h4, 1'b0);
    run_txn("rr4", 4'b0001, 4'h1, 1'b0);
    Request = 4'b0000;

    // Wrap: grant 2 sets ptr=3, then 1001 yields 3 then 0.
    Request     = 4'b0100;
    RequestData = 16'hC70E;
    run_txn("wrap2", 4'b0100, 4'h7, 1'b0);
    Request = 4'b1001;
    run_txn("wrap3", 4'b1000, 4'hC, 1'b0);
    run_txn("wrap0", 4'b0001, 4'hE, 1'b0);
    Request = 4'b0000;
    tick();
    check("wrap/error_clean", 32'(Error), 0);

    // Clear while RegLoad is high aborts the transaction.
    Request     = 4'b0010;
    RequestData = 16'h00B0;
    tick();
    tick();
    check("abort/grant", 32'(Grant), 32'b0010);
    tick();
    check("abort/load_high", 32'(RegLoad), 1);
    Request = 4'b0000;
    do_reset("abort");
    tick();
    check("abort/no_done1", 32'(Done), 0);
    tick();
    check("abort/no_done2", 32'(Done), 0);
    check("abort/idle_busy", 32'(Busy), 0);
    Request     = 4'b0100;
    RequestData = 16'h0500;
    run_txn("post_abort", 4'b0100, 4'h5, 1'b1);

    // Readback mismatch: register returns 0x5 for 0x6.
    corrupt     = 1'b1;
    Request     = 4'b0001;
    RequestData = 16'h0036;
    run_txn("rb_bad", 4'b0001, 4'h6, 1'b1);
    check("rb_bad/error", 32'(Error), 32'(EXP_ERR));
    Request     = 4'b0010;
    RequestData = 16'h0030;
    run_txn("rb_next", 4'b0010, 4'h3, 1'b1);
    check("rb_next/error_sticky", 32'(Error), 32'(EXP_ERR));
    tick();
    check("rb_next/idle_busy", 32'(Busy), 0);
    check("rb_next/error_still", 32'(Error), 32'(EXP_ERR));
    do_reset("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_load_arbiter.md
REG_LOAD_ARBITER -- requirements
Module: reg_load_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: data width of the shared gatedRegister.
REQ-002 SHALL have port Clock, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port Clear, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port Request, input, 4: Request[i] high means requester i wants one load of the shared register.
REQ-005 SHALL have port RequestData, input, 4*N: RequestData[i*N +: N] is requester i's load value.
REQ-006 SHALL have port Grant, output, 4: one-hot; identifies the owner of the current transaction.
REQ-007 SHALL have port Done, output, 4: one-cycle pulse on the owner's bit when its load completes.
REQ-008 SHALL have port RegLoad, output, 1: drives the register's Load input.
REQ-009 SHALL have port RegEnable, output, 1: drives the register's Enable input.
REQ-010 SHALL have port RegInputData, output, N: drives the register's InputData.
REQ-011 SHALL have port RegOutputData, input, N: readback of the register's OutputData.
REQ-012 SHALL have port Busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port Error, output, 1: readback mismatch flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, LOAD, HOLD, VERIFY (macro only), DONE; all outputs registered.
REQ-015 IDLE: when Request != 0 at an edge, pick the winner, latch its RequestData, set Grant, and go to SETUP; otherwise stay.
REQ-016 Winner selection SHALL be round-robin: search Request[ptr], [ptr+1], ... modulo 4, with 2-bit ptr wrapping 3->0.
REQ-017 SETUP SHALL drive RegEnable=1 and RegInputData=latched data with RegLoad=0, for one cycle (setup time).
REQ-018 LOAD SHALL drive RegLoad=1 for exactly one cycle; this produces the register's rising Load edge.
REQ-019 HOLD SHALL drive RegLoad=0 for one cycle while RegEnable and RegInputData remain stable (hold time).
REQ-020 DONE SHALL pulse Done[winner] for one cycle, clear Grant and RegEnable, set ptr = winner+1 mod 4, and go to IDLE.
REQ-021 Latency: request sampled at edge k -> Grant at k+1, RegLoad high k+2..k+3, Done pulse k+4..k+5 (k+5..k+6 with macro).
REQ-022 RegInputData SHALL hold its last value outside transactions; RegLoad and RegEnable SHALL be 0 in IDLE.
REQ-023 Request changes after the winner is latched SHALL NOT affect the transaction in flight; latched data is used.
REQ-024 A requester that keeps Request high after Done SHALL be treated as a new request, subject to round-robin order.
REQ-025 Simultaneous requests: only one Grant bit at a time; the others wait, and none waits more than 3 transactions.
REQ-026 Back-to-back: DONE->IDLE->SETUP; at least one IDLE cycle between transactions.

Reset
REQ-027 Clear low SHALL immediately force IDLE, Grant=0, Done=0, RegLoad=0, RegEnable=0, RegInputData=0, Busy=0, Error=0, ptr=0.
REQ-028 Clear asserted mid-transaction SHALL abort it with no Done pulse; requests are re-arbitrated from ptr=0 after release.

Configuration
REQ-029 Macro REG_LOAD_ARBITER_READBACK_EN SHALL, when defined, insert VERIFY between HOLD and DONE.
REQ-030 VERIFY SHALL compare RegOutputData to the latched data; on mismatch it sets Error=1 (sticky until Clear). DONE follows either way.
REQ-031 Without the macro, VERIFY does not exist, RegOutputData is ignored, and Error is tied to 0.

Verification
REQ-032 Single request: N=4, Request=0001, data 0xA -> Grant=0001 at k+1, RegLoad pulse of 1 cycle with RegInputData=0xA, Done=0001 pulse, Busy returns to 0.
REQ-033 Contention: Request=1111 held continuously, all data distinct -> Grant order 0001, 0010, 0100, 1000, 0001; each Done matches.
REQ-034 Wrap: ptr=3 after a grant to 2, Request=1001 -> grant 3 then 0.
REQ-035 Clear during LOAD -> all outputs 0 at once, no Done; after release Request=0100 -> normal transaction, Grant=0100.
REQ-036 Readback (macro): model the register to return 0x5 for a load of 0x6 -> Error=1 after VERIFY and stays 1 across the next transaction; without the macro Error stays 0.
